// File: rtl/puf_pkg.sv
// Shared types and constants for the RO-PUF response collector.
// State encoding, default sizes and the vote counter width helper.
package puf_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_TALLY,
    S_OUT
  } puf_state_e;

  localparam int PUF_RESP_BITS = 16;
  localparam int PUF_VOTES     = 5;

  // Enough bits to hold a count of 0..votes.
  function automatic int puf_cnt_w(input int votes);
    return $clog2(votes + 1);
  endfunction

endpackage

// File: rtl/puf_vote_tally.sv
// Per-bit vote accumulator: counts evaluations and ones for one RO pair.
// Flags the final vote, the majority result and whether all votes agreed.
module puf_vote_tally
  import puf_pkg::*;
#(
  parameter int VOTES = PUF_VOTES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  input  logic bit_i,
  output logic last_vote_o,
  output logic majority_o,
  output logic unanimous_o
);

  localparam int CW = puf_cnt_w(VOTES);

  localparam logic [CW-1:0] LAST = CW'(VOTES - 1);
  localparam logic [CW-1:0] ALL  = CW'(VOTES);
  localparam logic [CW-1:0] HALF = CW'(VOTES / 2);

  logic [CW-1:0] votes_q, votes_d;
  logic [CW-1:0] ones_q, ones_d;

  // Clear wins over increment; otherwise count one vote.
  always_comb begin
    votes_d = votes_q;
    ones_d  = ones_q;
    if (clr_i) begin
      votes_d = '0;
      ones_d  = '0;
    end else if (inc_i) begin
      votes_d = votes_q + CW'(1);
      ones_d  = ones_q + CW'(bit_i);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      votes_q <= '0;
      ones_q  <= '0;
    end else begin
      votes_q <= votes_d;
      ones_q  <= ones_d;
    end
  end

  assign last_vote_o = (votes_q == LAST);
  assign majority_o  = (ones_q > HALF);
  assign unanimous_o = (ones_q == '0) || (ones_q == ALL);

endmodule

// File: rtl/puf_response_collector.sv
// Majority-vote collector turning RO-PUF comparator bits into a response.
// Optional PUF_STABILITY_EN enables the per-bit unstable_mask output.
module puf_response_collector
  import puf_pkg::*;
#(
  parameter int RESP_BITS = PUF_RESP_BITS,
  parameter int VOTES     = PUF_VOTES,
  localparam int PW       = $clog2(RESP_BITS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 eval_req,
  input  logic                 eval_done,
  input  logic                 puf_bit,
  output logic [PW-1:0]        pair_sel,
  output logic                 busy,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [RESP_BITS-1:0] resp_data,
  output logic [RESP_BITS-1:0] unstable_mask
);

  localparam logic [PW-1:0] LAST_PAIR = PW'(RESP_BITS - 1);

  puf_state_e           state_q;
  logic                 eval_req_q;
  logic [PW-1:0]        pair_q;
  logic                 busy_q;
  logic                 valid_q;
  logic [RESP_BITS-1:0] data_q;

  logic t_clr;
  logic t_inc;
  logic t_last;
  logic t_maj;

  // Counters restart on an accepted start and after each tally.
  assign t_clr = ((state_q == S_IDLE) && start) || (state_q == S_TALLY);
  assign t_inc = (state_q == S_WAIT) && eval_done;

`ifdef PUF_STABILITY_EN
  logic                 t_unan;
  logic [RESP_BITS-1:0] mask_q;
`else
  logic                 t_unan_unused;
`endif

  puf_vote_tally #(
    .VOTES(VOTES)
  ) u_tally (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (t_clr),
    .inc_i      (t_inc),
    .bit_i      (puf_bit),
    .last_vote_o(t_last),
    .majority_o (t_maj),
`ifdef PUF_STABILITY_EN
    .unanimous_o(t_unan)
`else
    .unanimous_o(t_unan_unused)
`endif
  );

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      eval_req_q <= 1'b0;
      pair_q     <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
`ifdef PUF_STABILITY_EN
      mask_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            pair_q     <= '0;
            busy_q     <= 1'b1;
            eval_req_q <= 1'b1;
            state_q    <= S_REQ;
`ifdef PUF_STABILITY_EN
            mask_q     <= '0;
`endif
          end
        end
        S_REQ: begin
          eval_req_q <= 1'b0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (eval_done) begin
            if (t_last) begin
              state_q <= S_TALLY;
            end else begin
              eval_req_q <= 1'b1;
              state_q    <= S_REQ;
            end
          end
        end
        S_TALLY: begin
          data_q[pair_q] <= t_maj;
`ifdef PUF_STABILITY_EN
          mask_q[pair_q] <= ~t_unan;
`endif
          if (pair_q == LAST_PAIR) begin
            valid_q <= 1'b1;
            state_q <= S_OUT;
          end else begin
            pair_q     <= pair_q + PW'(1);
            eval_req_q <= 1'b1;
            state_q    <= S_REQ;
          end
        end
        S_OUT: begin
          if (resp_ready) begin
            valid_q <= 1'b0;
            pair_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign eval_req   = eval_req_q;
  assign pair_sel   = pair_q;
  assign busy       = busy_q;
  assign resp_valid = valid_q;
  assign resp_data  = data_q;
`ifdef PUF_STABILITY_EN
  assign unstable_mask = mask_q;
`else
  assign unstable_mask = '0;
`endif

endmodule

// File: tb/tb_puf_response_collector.sv
// Randomised bench for puf_response_collector with a vote-table model.
// Works with or without PUF_STABILITY_EN defined.
module tb_puf_response_collector;

  localparam int RB = 4;
  localparam int V  = 5;
  localparam int PW = $clog2(RB);
  localparam int MIN_LAT = 1 + RB * (2 * V + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          eval_done = 1'b0;
  logic          puf_bit = 1'b0;
  logic          resp_ready = 1'b0;
  logic          eval_req;
  logic          busy;
  logic          resp_valid;
  logic [PW-1:0] pair_sel;
  logic [RB-1:0] resp_data;
  logic [RB-1:0] unstable_mask;

  int checks = 0;
  int errors = 0;

  bit vt [RB][V];

  always #5 clk = ~clk;

  puf_response_collector #(
    .RESP_BITS(RB),
    .VOTES    (V)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .eval_req     (eval_req),
    .eval_done    (eval_done),
    .puf_bit      (puf_bit),
    .pair_sel     (pair_sel),
    .busy         (busy),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .unstable_mask(unstable_mask)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ones_of(input int p);
    int n = 0;
    for (int v = 0; v < V; v++) n += int'(vt[p][v]);
    return n;
  endfunction

  function automatic logic [RB-1:0] exp_resp();
    logic [RB-1:0] r = '0;
    for (int p = 0; p < RB; p++) r[p] = (2 * ones_of(p) > V);
    return r;
  endfunction

  function automatic logic [RB-1:0] exp_mask();
    logic [RB-1:0] r = '0;
`ifdef PUF_STABILITY_EN
    for (int p = 0; p < RB; p++)
      r[p] = (ones_of(p) != 0) && (ones_of(p) != V);
`endif
    return r;
  endfunction

  task automatic fill(input int mode);
    for (int p = 0; p < RB; p++)
      for (int v = 0; v < V; v++)
        vt[p][v] = (mode == 1) ? 1'b1 : 1'($urandom_range(1, 0));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req"}, eval_req, 0);
    chk({tag, "_sel"}, pair_sel, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_vld"}, resp_valid, 0);
    chk({tag, "_data"}, resp_data, 0);
    chk({tag, "_mask"}, unstable_mask, 0);
  endtask

  // Start a collection and act as comparator until resp_valid or abort.
  task automatic collect(input int maxd, input bit stray,
                         input int stop_after, output int evals,
                         output int lat);
    int idx = 0;
    int pend = -1;
    int cyc = 0;
    int bad = 0;
    bit prev = 0;
    evals = 0;
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      eval_done = 1'b0;
      puf_bit = 1'b0;
      if (pend == 0) begin
        eval_done = 1'b1;
        puf_bit = vt[idx / V][idx % V];
        idx++;
      end
      if (pend >= 0) pend--;
      if (eval_req) begin
        evals++;
        if (prev) bad++;
        if (pair_sel != PW'((evals - 1) / V)) bad++;
        pend = $urandom_range(maxd, 0);
        if (stray && !eval_done) begin
          eval_done = 1'b1;
          puf_bit = ~vt[idx / V][idx % V];
        end
      end
      if (!busy) bad++;
      prev = eval_req;
      if (resp_valid) begin
        lat = cyc;
        break;
      end
      if (stop_after != 0 && evals == stop_after) break;
    end
    chk("seq", bad, 0);
    if (stop_after == 0) chk("timeout", 32'(lat > 0), 1);
  endtask

  // Hold off the consumer, optionally poke start, then accept.
  task automatic drain(input int hold, input bit poke);
    logic [RB-1:0] d0 = resp_data;
    logic [RB-1:0] m0 = unstable_mask;
    int bad = 0;
    eval_done = 1'b0;
    puf_bit = 1'b0;
    resp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      start = poke && (i == 3);
      @(negedge clk);
      if (!resp_valid || !busy) bad++;
      if (resp_data !== d0 || unstable_mask !== m0) bad++;
    end
    start = 1'b0;
    chk("hold", bad, 0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("vld_drop", resp_valid, 0);
    chk("busy_drop", busy, 0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (eval_req || busy) bad++;
    end
    chk("stay_idle", bad, 0);
  endtask

  task automatic check_resp(input string tag, input int evals,
                            input int lat, input bit exact);
    chk({tag, "_evals"}, evals, RB * V);
    chk({tag, "_data"}, resp_data, exp_resp());
    chk({tag, "_mask"}, unstable_mask, exp_mask());
    if (exact) chk({tag, "_lat"}, lat, MIN_LAT);
  endtask

  initial begin
    int evals;
    int lat;
    bit mix [RB][V] = '{'{1, 1, 0, 0, 1}, '{0, 0, 1, 1, 0},
                        '{1, 1, 1, 1, 1}, '{0, 0, 0, 0, 0}};

    repeat (3) @(negedge clk);
    chk_idle("rst");
    rst_n = 1'b1;
    @(negedge clk);

    fill(1);
    collect(0, 0, 0, evals, lat);
    check_resp("ones", evals, lat, 1);
    drain(0, 0);

    vt = mix;
    collect(0, 0, 0, evals, lat);
    check_resp("mix", evals, lat, 1);
    drain(1, 0);

    fill(0);
    collect(2, 0, 0, evals, lat);
    check_resp("bp", evals, lat, 0);
    drain(10, 1);

    fill(1);
    @(negedge clk);
    eval_done = 1'b1;
    puf_bit = 1'b0;
    @(negedge clk);
    eval_done = 1'b0;
    chk("idle_stray", busy, 0);
    collect(0, 1, 0, evals, lat);
    check_resp("stray", evals, lat, 1);
    drain(2, 0);

    fill(0);
    vt[0][0] = 1'b1;
    collect(1, 0, 0, evals, lat);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_idle("async");
    @(negedge clk);
    rst_n = 1'b1;

    fill(0);
    collect(0, 0, 7, evals, lat);
    chk("mid_evals", evals, 7);
    chk("mid_sel", pair_sel, 1);
    eval_done = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_idle("mid");
    @(negedge clk);
    rst_n = 1'b1;
    fill(0);
    collect(0, 0, 0, evals, lat);
    check_resp("after", evals, lat, 1);
    drain(1, 0);

    for (int k = 0; k < 6; k++) begin
      fill(0);
      collect(3, k[0], 0, evals, lat);
      check_resp("rnd", evals, lat, 0);
      drain($urandom_range(4, 0), k[1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
